reg_bank: RTL and testbench

- Register-file responder for the tiny16 datapath.
- Executes the register-side control signals issued by the instruction controller: src/dst select, bus write, bus read and PC increment.
- Holds r0..r7: r0 = PC, r1 = link (JSR return), r7 = ALU temp operand, r2..r6 general purpose.
- Supplies registered ALU operands and a registered bus-read value to the shared-bus mux.

---
 rtl/reg_bank.sv | 131 +++++++++++++
 tb/tb_reg_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// tiny16 register file: r0 = PC, r1 = link, r6 = GP or stack pointer, r7 = ALU temp.
// Define REG_BANK_SP_EN to make r6 a stack pointer with sp_push/sp_pop ports.
module reg_bank #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
  parameter logic [WIDTH-1:0] STACK_TOP = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef REG_BANK_SP_EN
  input  logic             sp_push,
  input  logic             sp_pop,
`endif
  input  logic [WIDTH-1:0] bus_in,
  input  logic [2:0]       reg_src_sel,
  input  logic [2:0]       reg_dst_sel,
  input  logic             reg_in_en,
  input  logic             reg_out_en,
  input  logic             reg_pc_inc,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_out_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] pc
);

  localparam int               NREGS = 8;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
`ifdef REG_BANK_SP_EN
  localparam bit SP_EN = 1'b1;
`else
  localparam bit SP_EN = 1'b0;
`endif
  localparam logic [WIDTH-1:0] R6_RESET = SP_EN ? STACK_TOP : '0;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] dst_val;
  logic [WIDTH-1:0] wr_data;
  logic             sp_inc;
  logic             sp_dec;

  logic [WIDTH-1:0] bus_out_reg;
  logic             bus_out_valid_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;

`ifdef REG_BANK_SP_EN
  // Simultaneous push and pop cancel out.
  assign sp_inc = sp_pop & ~sp_push;
  assign sp_dec = sp_push & ~sp_pop;
`else
  assign sp_inc = 1'b0;
  assign sp_dec = 1'b0;
`endif

  assign src_val = regs_q[reg_src_sel];
  assign dst_val = regs_q[reg_dst_sel];
  // With the read port enabled, a write becomes a reg-to-reg move and bus_in is ignored.
  assign wr_data = reg_out_en ? src_val : bus_in;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [WIDTH-1:0] RST_VAL =
        (gi == 0) ? RESET_PC : ((gi == 6) ? R6_RESET : '0);

      logic [WIDTH-1:0] r_reg;
      logic [WIDTH-1:0] r_next;
      logic             hit;

      assign hit        = reg_in_en && (reg_dst_sel == 3'(gi));
      assign regs_q[gi] = r_reg;

      if (gi == 0) begin : g_pc
        always_comb begin
          r_next = r_reg;
          if (hit)
            r_next = wr_data;
          else if (reg_pc_inc)
            r_next = r_reg + ONE;
        end
      end else if (gi == 6) begin : g_sp
        always_comb begin
          r_next = r_reg;
          if (hit)
            r_next = wr_data;
          else if (sp_dec)
            r_next = r_reg - ONE;
          else if (sp_inc)
            r_next = r_reg + ONE;
        end
      end else begin : g_gp
        always_comb begin
          r_next = r_reg;
          if (hit)
            r_next = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst)
          r_reg <= RST_VAL;
        else
          r_reg <= r_next;
      end
    end
  endgenerate

  // Output snapshots use pre-edge register contents; no write forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_out_reg       <= '0;
      bus_out_valid_reg <= 1'b0;
      alu_a_reg         <= '0;
      alu_b_reg         <= '0;
    end else begin
      bus_out_reg       <= reg_out_en ? src_val : '0;
      bus_out_valid_reg <= reg_out_en;
      alu_a_reg         <= dst_val;
      alu_b_reg         <= src_val;
    end
  end

  assign bus_out       = bus_out_reg;
  assign bus_out_valid = bus_out_valid_reg;
  assign alu_a         = alu_a_reg;
  assign alu_b         = alu_b_reg;
  assign pc            = regs_q[0];

endmodule

// File: tb/tb_reg_bank.sv
// Randomized scoreboard bench for reg_bank; a plain-array register model predicts each cycle's outputs.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic [2:0]  reg_src_sel;
  logic [2:0]  reg_dst_sel;
  logic        reg_in_en;
  logic        reg_out_en;
  logic        reg_pc_inc;
  logic        sp_push;
  logic        sp_pop;
  logic [15:0] bus_out;
  logic        bus_out_valid;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] pc;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk          (clk),
    .rst          (rst),
`ifdef REG_BANK_SP_EN
    .sp_push      (sp_push),
    .sp_pop       (sp_pop),
`endif
    .bus_in       (bus_in),
    .reg_src_sel  (reg_src_sel),
    .reg_dst_sel  (reg_dst_sel),
    .reg_in_en    (reg_in_en),
    .reg_out_en   (reg_out_en),
    .reg_pc_inc   (reg_pc_inc),
    .bus_out      (bus_out),
    .bus_out_valid(bus_out_valid),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .pc           (pc)
  );

  typedef struct packed {
    logic [15:0] bus;
    logic        valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] model [8];
  int          errors = 0;
  int          checks = 0;
  int          txn    = 0;

`ifdef REG_BANK_SP_EN
  localparam bit SP = 1'b1;
`else
  localparam bit SP = 1'b0;
`endif

  // Apply one cycle of controls and queue what the register file should show afterwards.
  task automatic step(input bit r, input bit we, input bit oe, input bit inc,
                      input logic [2:0] src, input logic [2:0] dst,
                      input logic [15:0] din, input bit push, input bit pop);
    exp_t        e;
    logic [15:0] sv;
    @(negedge clk);
    rst = r; reg_in_en = we; reg_out_en = oe; reg_pc_inc = inc;
    reg_src_sel = src; reg_dst_sel = dst; bus_in = din;
    sp_push = push; sp_pop = pop;
    if (r) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      if (SP) model[6] = 16'hFFFF;
      e = '0;
    end else begin
      sv      = model[src];
      e.bus   = oe ? sv : 16'h0000;
      e.valid = oe;
      e.a     = model[dst];
      e.b     = sv;
      if (inc && !(we && dst == 3'd0)) model[0] = model[0] + 16'd1;
      if (SP && !(we && dst == 3'd6)) begin
        if (push && !pop) model[6] = model[6] - 16'd1;
        if (pop && !push) model[6] = model[6] + 16'd1;
      end
      if (we) model[dst] = oe ? sv : din;
    end
    e.pc = model[0];
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] dst, input logic [15:0] d);
    step(0, 1, 0, 0, 3'd0, dst, d, 0, 0);
  endtask

  task automatic rd(input logic [2:0] src);
    step(0, 0, 1, 0, src, 3'd0, 16'h0000, 0, 0);
  endtask

  function automatic void cmp(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s txn %0d got %h expected %h", name, txn, got, want);
    end
  endfunction

  // Monitor: every cycle that has a queued expectation is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("bus_out", bus_out, e.bus);
        cmp("bus_out_valid", {15'd0, bus_out_valid}, {15'd0, e.valid});
        cmp("alu_a", alu_a, e.a);
        cmp("alu_b", alu_b, e.b);
        cmp("pc", pc, e.pc);
        $display("txn %0d: bus_out=%h valid=%b alu_a=%h alu_b=%h pc=%h",
                 txn, bus_out, bus_out_valid, alu_a, alu_b, pc);
        txn++;
      end
    end
  end

  initial begin
    rst = 1'b1; bus_in = '0; reg_src_sel = '0; reg_dst_sel = '0;
    reg_in_en = 0; reg_out_en = 0; reg_pc_inc = 0; sp_push = 0; sp_pop = 0;

    // Reset, idle reads of every register, then three PC increments.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) rd(3'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Immediate write then read back.
    wr(3'd3, 16'h00A5);
    rd(3'd3);
    // Reg-to-reg copy ignores bus_in.
    wr(3'd2, 16'h1234);
    step(0, 1, 1, 0, 3'd2, 3'd5, 16'hFFFF, 0, 0);
    rd(3'd5);
    // Copy onto itself.
    step(0, 1, 1, 0, 3'd2, 3'd2, 16'hBEEF, 0, 0);
    rd(3'd2);
    // PC wrap, write-over-increment, and concurrent write elsewhere.
    wr(3'd0, 16'hFFFF);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 3'd0, 3'd0, 16'h0040, 0, 0);
    step(0, 1, 0, 1, 3'd0, 3'd1, 16'h0007, 0, 0);
    rd(3'd1);
    // Read-before-write on the same register.
    wr(3'd4, 16'h0011);
    step(0, 1, 0, 0, 3'd4, 3'd4, 16'h0022, 0, 0);
    step(0, 0, 0, 0, 3'd4, 3'd4, 16'h0000, 0, 0);
    // Stack pointer behaviour (push/pop are inert without the feature).
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rd(3'd6);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    rd(3'd6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(3'd6);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    rd(3'd6);
    step(0, 1, 0, 0, 3'd0, 3'd6, 16'h0100, 1, 0);
    rd(3'd6);

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(99) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
           $urandom_range(2) == 0, 3'($urandom_range(7)), 3'($urandom_range(7)),
           16'($urandom), $urandom_range(3) == 0, $urandom_range(3) == 0);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
